ftdi_loopback_top: RTL and testbench

- FPGA top level that bridges an FT2232H-style asynchronous byte FIFO interface to an internal 16-entry byte FIFO.
- Reads every byte the host sends and echoes it back to the host in order.
- Drives a status LED.
- Sits directly on the board pins; the bidirectional data bus is tri-stated inside this block.

---
 rtl/ftdi_loopback_top.sv | 243 ++++++++++++++++++++++++
 tb/tb_ftdi_loopback_top.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ftdi_loopback_top.sv
// ftdi_loopback_top
//
// Board-level bridge between an FT2232H-style asynchronous byte FIFO and an
// internal echo buffer. Every byte read from the host is pushed into a small
// FIFO and written back to the host in the same order. The bidirectional
// data bus is tri-stated here, directly at the pins.
//
// Ports:
//   in_ext_osc     system clock, 66 MHz nominal
//   in_reset       synchronous active-high reset
//   out_led        status LED
//   io_ftdi_data   FTDI data bus (driven only during write cycles)
//   in_ftdi_rxf_n  low = FTDI holds a byte for us
//   in_ftdi_txe_n  low = FTDI can accept a byte
//   out_ftdi_rd_n  read strobe, active low, registered
//   out_ftdi_wr_n  write strobe, active low, registered
//
// Build option:
//   LED_HEARTBEAT_EN  defined   -> LED toggles when the free-running
//                                  LED_DIV_BITS counter wraps
//                     undefined -> LED toggles once per byte read from FTDI
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | arbitrate: write if FIFO non-empty and txe_n low, else read
// RD_STROBE  | 3 cycles, rd_n low
// RD_RECOVER | 2 cycles, rd_n high; byte pushed at the end of the first one
// WR_SETUP   | 1 cycle, head byte placed on the bus, wr_n high
// WR_STROBE  | 3 cycles, wr_n low, data held
// WR_HOLD    | 1 cycle, wr_n high, data held, byte popped
//
// Pin outputs are registered from the current state, so each pin-level phase
// trails its state by one clock. The read byte is therefore captured on the
// same edge that raises rd_n, i.e. after the full 3-cycle low time.

module ftdi_loopback_top #(
  parameter int FIFO_DEPTH   = 16,
  parameter int LED_DIV_BITS = 25
) (
  input  logic       in_ext_osc,
  input  logic       in_reset,
  output logic       out_led,
  inout  wire  [7:0] io_ftdi_data,
  input  logic       in_ftdi_rxf_n,
  input  logic       in_ftdi_txe_n,
  output logic       out_ftdi_rd_n,
  output logic       out_ftdi_wr_n
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_STROBE,
    RD_RECOVER,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         tmr_q, tmr_d;

  logic [1:0]         rxf_sync_q, txe_sync_q;
  logic               rxf_n_s, txe_n_s;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               fifo_empty, fifo_full;
  logic               push, pop;

  logic               rd_n_q, wr_n_q;
  logic               bus_oe_q;
  logic [7:0]         bus_dout_q;
  logic               led_q;

  // ---------------------------------------------------------------------
  // Flag synchronizers
  // ---------------------------------------------------------------------
  always_ff @(posedge in_ext_osc) begin
    if (in_reset) begin
      rxf_sync_q <= 2'b11;
      txe_sync_q <= 2'b11;
    end else begin
      rxf_sync_q <= {rxf_sync_q[0], in_ftdi_rxf_n};
      txe_sync_q <= {txe_sync_q[0], in_ftdi_txe_n};
    end
  end

  assign rxf_n_s = rxf_sync_q[1];
  assign txe_n_s = txe_sync_q[1];

  // ---------------------------------------------------------------------
  // Echo FIFO
  // ---------------------------------------------------------------------
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));

  always_ff @(posedge in_ext_osc) begin
    if (push && !in_reset) begin
      mem[wr_ptr_q] <= io_ftdi_data;
    end
  end

  always_ff @(posedge in_ext_osc) begin
    if (in_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // push and pop come from mutually exclusive states
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        count_q  <= count_q + 1'b1;
      end else if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q  <= count_q - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge in_ext_osc) begin
    if (in_reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = (tmr_q != 2'd0) ? tmr_q - 2'd1 : 2'd0;
    push    = 1'b0;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        // write first so a continuous stream alternates read/write
        if (!fifo_empty && !txe_n_s) begin
          state_d = WR_SETUP;
          tmr_d   = 2'd0;
        end else if (!fifo_full && !rxf_n_s) begin
          state_d = RD_STROBE;
          tmr_d   = 2'd2;
        end
      end
      RD_STROBE: begin
        if (tmr_q == 2'd0) begin
          state_d = RD_RECOVER;
          tmr_d   = 2'd1;
        end
      end
      RD_RECOVER: begin
        // first recovery cycle ends on the edge that raises rd_n
        if (tmr_q == 2'd1) begin
          push = 1'b1;
        end
        if (tmr_q == 2'd0) begin
          state_d = IDLE;
        end
      end
      WR_SETUP: begin
        state_d = WR_STROBE;
        tmr_d   = 2'd2;
      end
      WR_STROBE: begin
        if (tmr_q == 2'd0) begin
          state_d = WR_HOLD;
        end
      end
      WR_HOLD: begin
        pop     = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        tmr_d   = 2'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Pin outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge in_ext_osc) begin
    if (in_reset) begin
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      bus_oe_q   <= 1'b0;
      bus_dout_q <= 8'h00;
    end else begin
      rd_n_q   <= (state_q != RD_STROBE);
      wr_n_q   <= (state_q != WR_STROBE);
      bus_oe_q <= (state_q == WR_SETUP) || (state_q == WR_STROBE) ||
                  (state_q == WR_HOLD);
      // latched once so the pop in WR_HOLD cannot disturb the hold time
      if (state_q == WR_SETUP) begin
        bus_dout_q <= mem[rd_ptr_q];
      end
    end
  end

  assign out_ftdi_rd_n = rd_n_q;
  assign out_ftdi_wr_n = wr_n_q;
  assign io_ftdi_data  = bus_oe_q ? bus_dout_q : 8'hzz;

  // ---------------------------------------------------------------------
  // Status LED
  // ---------------------------------------------------------------------
`ifdef LED_HEARTBEAT_EN
  logic [LED_DIV_BITS-1:0] hb_cnt_q;

  always_ff @(posedge in_ext_osc) begin
    if (in_reset) begin
      hb_cnt_q <= '0;
      led_q    <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_q + 1'b1;
      if (&hb_cnt_q) begin
        led_q <= ~led_q;
      end
    end
  end
`else
  always_ff @(posedge in_ext_osc) begin
    if (in_reset) begin
      led_q <= 1'b0;
    end else if (push) begin
      led_q <= ~led_q;
    end
  end
`endif

  assign out_led = led_q;

endmodule

// File: tb/tb_ftdi_loopback_top.sv
`timescale 1ns/1ps

module tb_ftdi_loopback_top;

  logic       clk = 1'b0;
  logic       in_reset;
  logic       out_led;
  wire  [7:0] ftdi_data;
  logic       rxf_n;
  logic       txe_n;
  logic       rd_n;
  logic       wr_n;

  always #7.5 clk = ~clk;

  // host emulator state
  int         offered = 0;
  int         taken = 0;
  logic       emu_drive = 1'b0;
  logic [7:0] emu_data = 8'h00;
  logic [7:0] next_byte = 8'h00;
  logic       probe_drive = 1'b0;
  logic [7:0] probe_data = 8'h00;

  assign ftdi_data = emu_drive ? emu_data : 8'hzz;
  assign ftdi_data = probe_drive ? probe_data : 8'hzz;
  assign rxf_n = (offered == taken);

  ftdi_loopback_top dut (
    .in_ext_osc    (clk),
    .in_reset      (in_reset),
    .out_led       (out_led),
    .io_ftdi_data  (ftdi_data),
    .in_ftdi_rxf_n (rxf_n),
    .in_ftdi_txe_n (txe_n),
    .out_ftdi_rd_n (rd_n),
    .out_ftdi_wr_n (wr_n)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: bytes handed to the DUT, expected back in order
  logic [7:0] sb_q[$];

  initial begin
    forever begin
      @(negedge rd_n);
      emu_data  = next_byte;
      emu_drive = 1'b1;
      sb_q.push_back(next_byte);
      next_byte = next_byte + 8'd1;
      taken++;
      @(posedge rd_n);
      emu_drive = 1'b0;
    end
  end

  // monitor
  int         cyc = 0;
  int         reads_cnt = 0;
  int         writes_cnt = 0;
  int         rd_rise_cyc = 0;
  int         wr_fall_cyc = 0;
  int         rd_low = 0;
  int         wr_low = 0;
  logic       prev_rd = 1'b1;
  logic       prev_wr = 1'b1;
  logic [7:0] prev_bus = 8'h00;
  logic [7:0] cur_w = 8'h00;
  logic       exp_led = 1'b0;
  logic       alt_en = 1'b0;
  logic       alt_prev = 1'b0;
  logic       have_last = 1'b0;
  logic       last_was_wr = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (alt_en && !alt_prev) have_last = 1'b0;
      alt_prev = alt_en;
      if (in_reset) begin
        sb_q.delete();
        exp_led = 1'b0;
        rd_low  = 0;
        wr_low  = 0;
        prev_rd = 1'b1;
        prev_wr = 1'b1;
        prev_bus = ftdi_data;
      end else begin
        chk(rd_n || wr_n, "strobe_overlap", {30'd0, rd_n, wr_n}, 3);
        if (!rd_n) begin
          chk(ftdi_data == emu_data, "bus_contention", ftdi_data, emu_data);
          rd_low++;
        end
        if (rd_n && !prev_rd) begin
          chk(rd_low == 3, "rd_pulse_width", rd_low, 3);
          rd_low = 0;
          reads_cnt++;
          rd_rise_cyc = cyc;
`ifndef LED_HEARTBEAT_EN
          exp_led = ~exp_led;
`endif
          if (alt_en && have_last) chk(last_was_wr, "alternation_rd", 0, 1);
          have_last = 1'b1;
          last_was_wr = 1'b0;
        end
        if (!wr_n && prev_wr) begin
          wr_fall_cyc = cyc;
          if (sb_q.size() == 0) begin
            chk(1'b0, "sb_underflow", 0, 1);
          end else begin
            cur_w = sb_q.pop_front();
            chk(prev_bus == cur_w, "wr_setup_data", prev_bus, cur_w);
          end
        end
        if (!wr_n) begin
          wr_low++;
          chk(ftdi_data == cur_w, "wr_data", ftdi_data, cur_w);
        end
        if (wr_n && !prev_wr) begin
          chk(wr_low == 3, "wr_pulse_width", wr_low, 3);
          chk(ftdi_data == cur_w, "wr_hold_data", ftdi_data, cur_w);
          wr_low = 0;
          writes_cnt++;
          if (alt_en && have_last) chk(!last_was_wr, "alternation_wr", 1, 0);
          have_last = 1'b1;
          last_was_wr = 1'b1;
        end
        prev_rd  = rd_n;
        prev_wr  = wr_n;
        prev_bus = ftdi_data;
      end
    end
  end

  typedef struct {
    int add_bytes;
    bit txe;
    int cycles;
    int exp_reads;
    int exp_writes;
    bit alt;
  } step_t;

  step_t steps[6];

  initial begin
    int  r0;
    int  w0;
    int  k;
    bit  seen;

    steps[0] = '{10, 1'b0, 300, 10, 10, 1'b1};  // streaming echo
    steps[1] = '{20, 1'b1, 300, 16,  0, 1'b0};  // fill to full, 4 left waiting
    steps[2] = '{ 0, 1'b0, 400,  4, 20, 1'b0};  // drain, reads resume
    steps[3] = '{ 3, 1'b1, 100,  3,  0, 1'b0};
    steps[4] = '{ 0, 1'b0, 100,  0,  3, 1'b0};
    steps[5] = '{ 1, 1'b0,  60,  1,  1, 1'b0};

    // reset
    in_reset    = 1'b1;
    txe_n       = 1'b1;
    probe_data  = 8'hA5;
    probe_drive = 1'b1;
    repeat (4) @(negedge clk);
    chk(rd_n == 1'b1, "reset_rd_n", rd_n, 1);
    chk(wr_n == 1'b1, "reset_wr_n", wr_n, 1);
    chk(out_led == 1'b0, "reset_led", out_led, 0);
    chk(ftdi_data == 8'hA5, "reset_bus_released", ftdi_data, 8'hA5);
    in_reset    = 1'b0;
    probe_drive = 1'b0;

    r0 = reads_cnt;
    w0 = writes_cnt;
    repeat (100) @(negedge clk);
    chk(reads_cnt - r0 == 0, "idle_reads", reads_cnt - r0, 0);
    chk(writes_cnt - w0 == 0, "idle_writes", writes_cnt - w0, 0);

    // single echo, txe_n released 150 ns after rxf_n
    r0 = reads_cnt;
    w0 = writes_cnt;
    offered++;
    repeat (10) @(negedge clk);
    txe_n = 1'b0;
    repeat (60) @(negedge clk);
    chk(reads_cnt - r0 == 1, "echo_reads", reads_cnt - r0, 1);
    chk(writes_cnt - w0 == 1, "echo_writes", writes_cnt - w0, 1);
    chk(out_led == exp_led, "echo_led", out_led, exp_led);

    // read latency and echo latency with txe_n already low
    r0 = reads_cnt;
    w0 = writes_cnt;
    offered++;
    k = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!seen && rd_n == 1'b0) begin
        seen = 1'b1;
        k = i;
      end
    end
    repeat (40) @(negedge clk);
    chk(k == 4, "read_latency", k, 4);
    chk(writes_cnt - w0 == 1, "latency_writes", writes_cnt - w0, 1);
    chk(wr_fall_cyc - rd_rise_cyc == 4, "echo_latency", wr_fall_cyc - rd_rise_cyc, 4);

    // table-driven steps
    for (int s = 0; s < 6; s++) begin
      alt_en = steps[s].alt;
      txe_n  = steps[s].txe;
      r0 = reads_cnt;
      w0 = writes_cnt;
      offered += steps[s].add_bytes;
      repeat (steps[s].cycles) @(negedge clk);
      chk(reads_cnt - r0 == steps[s].exp_reads, $sformatf("step%0d_reads", s),
          reads_cnt - r0, steps[s].exp_reads);
      chk(writes_cnt - w0 == steps[s].exp_writes, $sformatf("step%0d_writes", s),
          writes_cnt - w0, steps[s].exp_writes);
      chk(out_led == exp_led, $sformatf("step%0d_led", s), out_led, exp_led);
      alt_en = 1'b0;
    end

    // reset in the middle of a read strobe
    txe_n = 1'b1;
    offered++;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rd_n == 1'b0) seen = 1'b1;
    end
    chk(seen, "midrst_read_started", seen, 1);
    in_reset = 1'b1;
    @(negedge clk);
    chk(rd_n == 1'b1, "midrst_rd_n", rd_n, 1);
    chk(wr_n == 1'b1, "midrst_wr_n", wr_n, 1);
    in_reset = 1'b0;
    txe_n = 1'b0;
    r0 = reads_cnt;
    w0 = writes_cnt;
    repeat (60) @(negedge clk);
    chk(writes_cnt - w0 == 0, "midrst_no_write", writes_cnt - w0, 0);
    chk(reads_cnt - r0 == 0, "midrst_no_read", reads_cnt - r0, 0);
    chk(out_led == exp_led, "midrst_led", out_led, exp_led);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
